tick_sched: RTL
===============

# tick_sched

Programmable tick scheduler that shares one free-running prescaler among four divided clock-enable channels. It replaces the per-ratio ripple dividers with a single-clock scheme: every output is a clock enable or a registered square wave, never a derived clock. It sits between the board clock and the LED/display logic. Ratios are reconfigured at runtime through a valid/ready port and applied glitch-free at each channel's period boundary.

## Interface
- PRESCALE, 50000: clk cycles per base tick; must be ≥1.
- N_CH, 4: number of channels (fixed at 4 in the package).
- DIV_W, 8: width of the per-channel divide ratio.
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a request; a transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_ch  in  2  target channel.
- cfg_div  in  DIV_W  divide ratio D in base ticks; 0 means disable.
- cfg_en  in  1  1 = run channel, 0 = stop channel.
- tick  out  N_CH  per-channel one-clk enable pulse, once per period.
- wave  out  N_CH  per-channel square wave; toggles on every tick.

## Operation
- Prescaler pre_cnt counts 0..PRESCALE-1 and wraps. base_tick = (pre_cnt == PRESCALE-1), combinational and internal. The prescaler free-runs and is never paused by configuration.
- Each channel holds cnt[DIV_W], div, and en.
- On a clk edge with base_tick && en:
  - if cnt == div-1: cnt←0, tick←1, wave toggles (this is the "wrap" event);
  - otherwise cnt←cnt+1, tick←0.
- tick is registered and is 0 on every edge that is not a wrap.
- Effective enable is cfg_en && (cfg_div != 0). A request with cfg_div = 0 stores div = 1 and en = 0.
- Config FSM, two states:
  - IDLE: cfg_ready = 1. On a transfer, latch {ch, div, en} into the pending register and move to PENDING.
  - PENDING: cfg_ready = 0.
    - If the target channel is currently disabled, apply on the next edge and return to IDLE.
    - If it is enabled, apply on the edge of that channel's next wrap and return to IDLE. The wrap fires normally on that edge (tick = 1, wave toggles); the new div governs the following period.
- Apply with en = 0: cnt←0, wave←0, tick←0. The channel stays silent until re-enabled.
- Apply that enables a disabled channel: cnt←0, wave←0. The first tick occurs on the D-th base_tick after the apply edge. A base_tick coincident with the apply edge is not counted.
- Only one request is pending at a time, across all channels. Requests to other channels wait on cfg_ready.
- A request that does not change a running channel's settings still waits for that channel's wrap.
- cfg_ready = (state == IDLE) && !reset, so no transfer is possible while reset is high.

## Timing
- Reset (synchronous, takes effect on the edge where reset = 1):
  - pre_cnt = 0; all cnt = 0, div = 1, en = 0; tick = 0, wave = 0.
  - FSM to IDLE; the pending request is discarded.
  - cfg_ready = 0 while reset is high and 1 in the first cycle after.
- Tick period is PRESCALE·D clk cycles. wave period is 2·PRESCALE·D clk cycles with 50 % duty. tick is high for exactly 1 clk.
- PRESCALE = 1: base_tick is 1 every cycle; D = 1 then gives tick = 1 continuously and wave toggling every clk.
- Config latency on a disabled channel: transfer at edge k, settings active from edge k+1, cfg_ready = 1 after edge k+1.
- Config latency on an enabled channel: up to PRESCALE·D_old + 1 cycles.
- A transfer on the same edge as the target channel's wrap is not applied at that wrap; it waits for the next one.
- Changing div never produces a period shorter than min(D_old, D_new) base ticks, and never produces a partial pulse.
- Reset mid-PENDING: the request is lost and the channel keeps reset values.

## Structure
- Package tick_sched_pkg: N_CH = 4, DIV_W = 8, typedef cfg_t {ch, div, en}, typedef enum {IDLE, PENDING} cfg_state_t.
- Sub-module tick_chan, instantiated N_CH times:
  - inputs: clk, reset, base_tick, apply, cfg_t fields;
  - outputs: tick, wave, wrap, en.
- Top tick_sched holds the prescaler, the pending register and the FSM. It generates apply[i] from the FSM state together with wrap[i] and en[i].
- Target 150–250 lines total.

## Test plan
All scenarios use PRESCALE = 4.
- Reset, then cfg ch0 D = 3, en = 1 → cfg_ready low for exactly 1 cycle; tick[0] pulses every 12 clk; wave[0] period is 24 clk; first pulse on the 3rd base_tick after apply.
- Running ch0 at D = 3, cfg D = 5 → cfg_ready stays low until ch0 wraps; tick intervals 12, then 20, 20…; no short interval; wave has no glitch.
- ch1 running at D = 2, cfg ch1 en = 0 → final tick lands on schedule, then tick[1] = 0 and wave[1] = 0 permanently; cfg_ready returns 1 cycle later.
- cfg ch2 D = 0, en = 1 → ch2 stays disabled: tick[2] = 0, wave[2] = 0.
- cfg_valid held high, first ch0 (running) then ch3 (idle) → ch3 request accepted only on the cycle after ch0's apply; ch3 applied 1 edge after that.
- Reset asserted for 1 cycle while PENDING on ch0 → all tick/wave = 0; cfg_ready = 0 during reset and 1 the next cycle; ch0 remains disabled.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types for the tick scheduler: channel count, ratio width, config record and FSM states.
package tick_sched_pkg;
   localparam int N_CH  = 4;
   localparam int DIV_W = 8;
   localparam int CH_W  = 2;

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [DIV_W-1:0] div;
      logic             en;
   } cfg_t;

   typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} cfg_state_t;

   // A zero ratio is stored as 1 with the channel stopped.
   function automatic cfg_t norm_cfg(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] div,
                                     input logic en);
      cfg_t c;
      c.ch  = ch;
      c.div = (div == '0) ? DIV_W'(1) : div;
      c.en  = en && (div != '0);
      return c;
   endfunction
endpackage

// File: rtl/tick_sched_if.sv
// Configuration handshake and tick/wave outputs of the tick scheduler.
interface tick_sched_if;
   import tick_sched_pkg::*;

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [CH_W-1:0]       cfg_ch;
   logic [DIV_W-1:0]      cfg_div;
   logic                  cfg_en;
   logic [N_CH-1:0]       tick;
   logic [N_CH-1:0]       wave;

   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready, tick, wave);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready, tick, wave);
endinterface

// File: rtl/tick_sched_chan.sv
// One divided clock-enable channel: counts base ticks, pulses tick and toggles wave on wrap.
module tick_chan
   import tick_sched_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             base_tick,
   input  logic             apply,
   input  logic [DIV_W-1:0] new_div,
   input  logic             new_en,
   output logic             tick,
   output logic             wave,
   output logic             wrap,
   output logic             en
);
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;

   assign wrap = base_tick && en && (cnt == div - DIV_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         div  <= DIV_W'(1);
         en   <= 1'b0;
         tick <= 1'b0;
         wave <= 1'b0;
      end else if (apply) begin
         // On a running channel apply coincides with its wrap, which still fires.
         cnt  <= '0;
         div  <= new_div;
         en   <= new_en;
         tick <= wrap;
         wave <= (wrap && new_en) ? ~wave : 1'b0;
      end else if (base_tick && en) begin
         if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            wave <= ~wave;
         end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end
endmodule

// File: rtl/tick_sched.sv
// Shared prescaler, single pending-config register and apply FSM feeding N_CH tick channels.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int PRESCALE = 50000
) (
   input  logic         clk,
   input  logic         reset,
   tick_sched_if.slave  bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]   pre_cnt;
   logic            base_tick;
   cfg_state_t      state;
   cfg_t            pend;
   logic [N_CH-1:0] wrap;
   logic [N_CH-1:0] en;
   logic [N_CH-1:0] apply;
   logic [N_CH-1:0] tick_v;
   logic [N_CH-1:0] wave_v;

   assign base_tick = (pre_cnt == PW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (reset || base_tick) pre_cnt <= '0;
      else                    pre_cnt <= pre_cnt + PW'(1);
   end

   assign bus.cfg_ready = (state == IDLE) && !reset;

   // Disabled targets take the request at once; running ones wait for their wrap.
   always_comb begin
      apply = '0;
      for (int i = 0; i < N_CH; i++)
         apply[i] = (state == PENDING) && (pend.ch == CH_W'(i)) && (!en[i] || wrap[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.cfg_valid) begin
               pend  <= norm_cfg(bus.cfg_ch, bus.cfg_div, bus.cfg_en);
               state <= PENDING;
            end
            PENDING: if (|apply) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tick_chan u_ch (
         .clk       (clk),
         .reset     (reset),
         .base_tick (base_tick),
         .apply     (apply[i]),
         .new_div   (pend.div),
         .new_en    (pend.en),
         .tick      (tick_v[i]),
         .wave      (wave_v[i]),
         .wrap      (wrap[i]),
         .en        (en[i])
      );
   end

   assign bus.tick = tick_v;
   assign bus.wave = wave_v;
endmodule
